// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the transmit and receive sides
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic START_BIT            = 1'b0;
    localparam logic STOP_BIT             = 1'b1;
    localparam int   FRAME_BITS           = 11;
    localparam int   DEFAULT_CLKS_PER_BIT = 8;

    // Even parity: XOR of the data bits keeps the total count of ones even.
    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - mod-N bit-period counter producing a one-cycle tick
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            count <= '0;
        end else if (i_clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign o_tick = (count == LAST);

endmodule

// File: rtl/uart_transmitter.sv
// rtl/uart_transmitter.sv - serialises one byte into start/8 data/even parity/stop frame
module uart_transmitter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [DATA_W-1:0] i_datain,
    input  logic              i_valid,
    output logic              o_ready,
    output logic              o_dataout,
    output logic              o_done
);

    tx_state_t         state, state_nxt;
    logic [DATA_W-1:0] shreg, shreg_nxt;
    logic [2:0]        bit_cnt, bit_cnt_nxt;
    logic              parity, parity_nxt;
    logic              dout_nxt;
    logic              tick;
    logic              accept;

    assign o_ready = (state == IDLE);
    assign accept  = i_valid && o_ready;

    // Clearing the timer on accept aligns every bit boundary to the accept edge.
    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (accept),
        .o_tick  (tick)
    );

    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        bit_cnt_nxt = bit_cnt;
        parity_nxt  = parity;
        dout_nxt    = o_dataout;
        o_done      = 1'b0;
        case (state)
            IDLE: begin
                dout_nxt = STOP_BIT;
                if (accept) begin
                    state_nxt  = START;
                    shreg_nxt  = i_datain;
                    parity_nxt = even_parity(i_datain);
                    dout_nxt   = START_BIT;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt   = DATA;
                    dout_nxt    = shreg[0];
                    shreg_nxt   = shreg >> 1;
                    bit_cnt_nxt = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    bit_cnt_nxt = bit_cnt + 3'd1;
                    if (bit_cnt == 3'(DATA_W - 1)) begin
                        state_nxt = PARITY;
                        dout_nxt  = parity;
                    end else begin
                        dout_nxt  = shreg[0];
                        shreg_nxt = shreg >> 1;
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    state_nxt = STOP;
                    dout_nxt  = STOP_BIT;
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    o_done    = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                dout_nxt  = STOP_BIT;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            parity    <= 1'b0;
            o_dataout <= STOP_BIT;
        end else begin
            state     <= state_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
            parity    <= parity_nxt;
            o_dataout <= dout_nxt;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb/tb_uart_transmitter.sv - scoreboard bench for uart_transmitter
module tb_uart_transmitter;
    import uart_pkg::*;

    localparam int N         = 8;
    localparam int FRAME_CYC = FRAME_BITS * N;

    logic       clk = 1'b0;
    logic       i_reset;
    logic [7:0] i_datain;
    logic       i_valid;
    logic       o_ready;
    logic       o_dataout;
    logic       o_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [10:0] exp_q[$];
    int          acc_log[$];

    uart_transmitter #(
        .CLKS_PER_BIT(N),
        .DATA_W(8)
    ) dut (
        .i_clk     (clk),
        .i_reset   (i_reset),
        .i_datain  (i_datain),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_dataout (o_dataout),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: frames are {stop, parity, data[7:0], start}, so bit k of the vector is frame bit k.
    initial begin : monitor
        logic [10:0] frm;
        int          t0;
        bit          active;
        active = 1'b0;
        t0     = 0;
        frm    = '0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!i_reset) begin
                active = 1'b0;
                chk("rst_dout", o_dataout, 1);
                chk("rst_ready", o_ready, 1);
                chk("rst_done", o_done, 0);
            end else begin
                if (active) begin
                    if (cyc <= t0 + FRAME_CYC) begin
                        chk("frame_bit", o_dataout, frm[(cyc - t0 - 1) / N]);
                        chk("busy_ready", o_ready, 0);
                        chk("done_pulse", o_done, (cyc == t0 + FRAME_CYC));
                    end else begin
                        chk("ready_return", o_ready, 1);
                        chk("post_dout", o_dataout, 1);
                        chk("post_done", o_done, 0);
                        active = 1'b0;
                    end
                end else begin
                    chk("idle_dout", o_dataout, 1);
                    chk("idle_ready", o_ready, 1);
                    chk("idle_done", o_done, 0);
                end
                if (!active && o_ready && i_valid) begin
                    acc_log.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_accept", 1, 0);
                    end else begin
                        frm    = exp_q.pop_front();
                        t0     = cyc;
                        active = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_accept();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(o_ready && i_reset) && n < 300);
        if (n >= 300) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic [10:0] frame, input bit hold);
        exp_q.push_back(frame);
        i_datain = b;
        i_valid  = 1'b1;
        wait_accept();
        if (!hold) i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!o_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("idle_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin : driver
        int sz;
        i_reset  = 1'b0;
        i_valid  = 1'b1;
        i_datain = 8'hAA;
        repeat (4) @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // A5 has four ones -> parity 0
        send(8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}, 1'b0);
        wait_idle();
        // 07 has three ones -> parity 1; 00 -> parity 0
        send(8'h07, {1'b1, 1'b1, 8'h07, 1'b0}, 1'b0);
        wait_idle();
        send(8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 1'b0);
        wait_idle();

        send(8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}, 1'b1);
        send(8'h00, {1'b1, 1'b0, 8'h00, 1'b0}, 1'b0);
        sz = acc_log.size();
        if (sz >= 2) chk("b2b_gap", acc_log[sz-1] - acc_log[sz-2], FRAME_CYC + 1);
        else chk("b2b_log", sz, 2);
        wait_idle();

        // 5A has four ones -> parity 0; the 3C offer while busy must be ignored
        send(8'h5A, {1'b1, 1'b0, 8'h5A, 1'b0}, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        i_valid  = 1'b1;
        i_datain = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            i_datain = ~i_datain;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        wait_idle();

        // C3 data bit 3 is 0, so a line forced high by reset is visible
        send(8'hC3, {1'b1, 1'b0, 8'hC3, 1'b0}, 1'b0);
        repeat (4 * N + 3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        #1;
        chk("async_abort", o_dataout, 1);
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        // 81 has two ones -> parity 0
        send(8'h81, {1'b1, 1'b0, 8'h81, 1'b0}, 1'b0);
        wait_idle();

        chk("queue_empty", exp_q.size(), 0);
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
